instr_writer: RTL

Write-side counterpart of the instruction fetch path: accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into the instruction memory that fetch reads. The memory is written at consecutive addresses from a programmed base address. A small internal FIFO decouples the producer from the memory write port. A start/done control pair frames each load, so the same block loads programs, patches regions or refills the memory between runs.

---
 rtl/instr_writer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/instr_writer.sv
`default_nettype none
// ============================================================================
// Module      : instr_writer
// Description : Loads a stream of instruction words into instruction memory.
//               Words arrive over valid/ready, pass through a small FIFO and
//               are written at consecutive (wrapping) addresses starting from
//               a base address latched on start. A done pulse closes each load.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done
);

    localparam int                  c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]    c_cnt_one  = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w:0]    c_cnt_full = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_ptr_w-1:0]  c_idx_one  = (c_ptr_w)'(1);
    localparam logic [ADDR_WIDTH:0] c_len_one  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] c_len_zero = '0;
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = (ADDR_WIDTH)'(1);

    typedef enum logic [1:0] {
        c_st_idle  = 2'd0,
        c_st_write = 2'd1,
        c_st_done  = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_accept_rem;
    logic [ADDR_WIDTH:0]   r_write_rem;

    logic [DATA_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_head;
    logic [c_ptr_w-1:0]    r_tail;
    logic [c_ptr_w:0]      r_count;
    logic                  r_full;

    logic                  w_in_write;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [c_ptr_w:0]      w_count_nxt;

    assign w_in_write = (r_state == c_st_write);
    assign w_empty    = (r_count == '0);

    // Accept only while loading, with room in the FIFO and words still owed.
    // Uses the registered full flag, so a same-cycle pop never frees a slot.
    assign in_ready = w_in_write && !r_full && (r_accept_rem != c_len_zero);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = w_in_write && !w_empty && (r_write_rem != c_len_zero);

    // Next FIFO occupancy; simultaneous push and pop leave it unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage; contents are qualified by the occupancy count, so no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_tail] <= in_data;
        end
    end

    // FIFO pointers, occupancy and registered full flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_idx_one;
            end
            if (w_pop) begin
                r_head <= r_head + c_idx_one;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_cnt_full);
        end
    end

    // Load sequencing, counters and registered memory-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_wr_ptr     <= '0;
            r_accept_rem <= '0;
            r_write_rem  <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    busy <= 1'b0;
                    if (start) begin
                        r_wr_ptr     <= base_addr;
                        r_accept_rem <= length;
                        r_write_rem  <= length;
                        if (length != c_len_zero) begin
                            r_state <= c_st_write;
                            busy    <= 1'b1;
                        end else begin
                            r_state <= c_st_done;
                            done    <= 1'b1;
                        end
                    end
                end
                c_st_write: begin
                    if (w_push) begin
                        r_accept_rem <= r_accept_rem - c_len_one;
                    end
                    if (w_pop) begin
                        mem_we      <= 1'b1;
                        mem_addr    <= r_wr_ptr;
                        mem_wdata   <= r_fifo[r_head];
                        r_wr_ptr    <= r_wr_ptr + c_addr_one;
                        r_write_rem <= r_write_rem - c_len_one;
                    end
                    // Last write was registered on the previous edge
                    if (r_write_rem == c_len_zero) begin
                        r_state <= c_st_done;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= c_st_idle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
